acc_eng_ctrl_mc: RTL and testbench

Multi-engine kernel controller for the conv accelerator and the parametrised successor of the single-engine ap_ctrl_chain controller. It accepts ap_start jobs into a pending-job counter and dispatches each job to an idle engine in round-robin order with a one-cycle op_start pulse. Per engine it tracks end_conv followed by write-master completion. It reports each completed job through a counted ap_done/ap_continue handshake, so completions that arrive back-to-back are never lost.

---
 rtl/acc_eng_ctrl_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_acc_eng_ctrl_mc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_eng_ctrl_mc.sv
// acc_eng_ctrl_mc
// Multi-engine kernel controller for the conv accelerator. Accepts ap_start
// jobs into a pending counter, dispatches them round-robin to idle engines
// with a one-cycle op_start pulse, tracks end_conv then write-master
// completion per engine, and reports each completion through a counted
// ap_done/ap_continue handshake.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   ap_start     job request
//   ap_continue  acknowledges one ap_done
//   ap_ready     a job can be accepted this cycle
//   ap_done      at least one unacknowledged completion exists
//   ap_idle      no pending jobs and every engine idle
//   op_start     per-engine one-cycle start pulse
//   end_conv     per-engine compute-finished pulse
//   wmst_done    per-engine write-master finished pulse
//   perf_busy_cyc, perf_jobs  (only with ACC_ENG_PERF_EN) saturating counters
//
// Optional feature macro: ACC_ENG_PERF_EN adds the performance counters.
//
// Engine FSM states:
//   state    | meaning
//   ENG_IDLE | free, eligible for dispatch
//   ENG_RUN  | computing, waiting for end_conv
//   ENG_WB   | compute done, waiting for wmst_done

module acc_eng_ctrl_mc #(
  parameter int NUM_ENG   = 4,
  parameter int JOB_DEPTH = 4,
  parameter int PEND_W    = $clog2(JOB_DEPTH + 1),
  parameter int DONE_W    = $clog2(NUM_ENG + JOB_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ap_start,
  input  logic               ap_continue,
  output logic               ap_ready,
  output logic               ap_done,
  output logic               ap_idle,
  output logic [NUM_ENG-1:0] op_start,
  input  logic [NUM_ENG-1:0] end_conv,
  input  logic [NUM_ENG-1:0] wmst_done
`ifdef ACC_ENG_PERF_EN
  ,
  output logic [31:0]        perf_busy_cyc,
  output logic [31:0]        perf_jobs
`endif
);

  localparam int RR_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int CNT_W = $clog2(NUM_ENG + 1);
  localparam int SUM_W = DONE_W + 1;

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(JOB_DEPTH);
  localparam logic [SUM_W-1:0]  DONE_MAX = SUM_W'(NUM_ENG + JOB_DEPTH);
  localparam logic [RR_W-1:0]   RR_LAST  = RR_W'(NUM_ENG - 1);

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_WB   = 2'd2
  } eng_state_t;

  eng_state_t         eng_q [NUM_ENG];
  eng_state_t         eng_d [NUM_ENG];

  logic [PEND_W-1:0]  pend_cnt;
  logic [PEND_W-1:0]  pend_nxt;
  logic [DONE_W-1:0]  done_cnt;
  logic [DONE_W-1:0]  done_nxt;
  logic [SUM_W-1:0]   done_sum;
  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    rr_nxt;
  logic [RR_W-1:0]    sel_idx;
  logic               sel_found;
  logic               disp_vld;
  logic               accept;
  logic               ack;
  logic [NUM_ENG-1:0] eng_idle;
  logic [NUM_ENG-1:0] disp_vec;
  logic [NUM_ENG-1:0] cmpl_vec;
  logic [CNT_W-1:0]   cmpl_cnt;

  // All handshake outputs decode registered state only.
  assign ap_ready = (pend_cnt < PEND_MAX);
  assign ap_idle  = (pend_cnt == '0) && (&eng_idle);
  assign accept   = ap_start && ap_ready;
  assign ack      = ap_continue && ap_done;

  always_comb begin
    eng_idle = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      eng_idle[i] = (eng_q[i] == ENG_IDLE);
    end
  end

  // Round-robin pick: first idle engine at or after rr_ptr, with wrap.
  // Uses registered engine state, so an engine that just went idle waits
  // one cycle before it can be picked.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = 0; j < NUM_ENG; j++) begin
      if (!sel_found && eng_idle[(int'(rr_ptr) + j) % NUM_ENG]) begin
        sel_found = 1'b1;
        sel_idx   = RR_W'((int'(rr_ptr) + j) % NUM_ENG);
      end
    end
  end

  assign disp_vld = sel_found && (pend_cnt != '0);

  always_comb begin
    disp_vec = '0;
    rr_nxt   = rr_ptr;
    if (disp_vld) begin
      disp_vec[sel_idx] = 1'b1;
      rr_nxt = (sel_idx == RR_LAST) ? '0 : sel_idx + RR_W'(1);
    end
  end

  // Engine next-state and completion detection.
  always_comb begin
    for (int i = 0; i < NUM_ENG; i++) begin
      eng_d[i]    = eng_q[i];
      cmpl_vec[i] = 1'b0;
      case (eng_q[i])
        ENG_IDLE: begin
          if (disp_vec[i]) eng_d[i] = ENG_RUN;
        end
        ENG_RUN: begin
          if (end_conv[i]) begin
            if (wmst_done[i]) begin
              eng_d[i]    = ENG_IDLE;
              cmpl_vec[i] = 1'b1;
            end else begin
              eng_d[i] = ENG_WB;
            end
          end
        end
        ENG_WB: begin
          if (wmst_done[i]) begin
            eng_d[i]    = ENG_IDLE;
            cmpl_vec[i] = 1'b1;
          end
        end
        default: eng_d[i] = ENG_IDLE;
      endcase
    end
  end

  always_comb begin
    cmpl_cnt = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      cmpl_cnt = cmpl_cnt + CNT_W'(cmpl_vec[i]);
    end
  end

  always_comb begin
    pend_nxt = pend_cnt;
    if (accept && !disp_vld) begin
      pend_nxt = pend_cnt + PEND_W'(1);
    end else if (!accept && disp_vld) begin
      pend_nxt = pend_cnt - PEND_W'(1);
    end
  end

  // One extra bit keeps the sum from wrapping; ack only happens with
  // done_cnt > 0, so the subtraction cannot underflow.
  always_comb begin
    done_sum = SUM_W'(done_cnt) + SUM_W'(cmpl_cnt) - SUM_W'(ack);
    if (done_sum > DONE_MAX) begin
      done_nxt = DONE_W'(DONE_MAX);
    end else begin
      done_nxt = DONE_W'(done_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
      done_cnt <= '0;
      rr_ptr   <= '0;
      op_start <= '0;
      ap_done  <= 1'b0;
      for (int i = 0; i < NUM_ENG; i++) begin
        eng_q[i] <= ENG_IDLE;
      end
    end else begin
      pend_cnt <= pend_nxt;
      done_cnt <= done_nxt;
      rr_ptr   <= rr_nxt;
      op_start <= disp_vec;
      ap_done  <= (done_nxt != '0);
      for (int i = 0; i < NUM_ENG; i++) begin
        eng_q[i] <= eng_d[i];
      end
    end
  end

`ifdef ACC_ENG_PERF_EN
  logic [32:0] perf_jobs_sum;

  assign perf_jobs_sum = {1'b0, perf_jobs} + 33'(cmpl_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc <= '0;
      perf_jobs     <= '0;
    end else begin
      if (!ap_idle && (perf_busy_cyc != 32'hFFFF_FFFF)) begin
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      end
      perf_jobs <= perf_jobs_sum[32] ? 32'hFFFF_FFFF : perf_jobs_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_acc_eng_ctrl_mc.sv
// Directed testbench for acc_eng_ctrl_mc with NUM_ENG=4, JOB_DEPTH=4.
module tb_acc_eng_ctrl_mc;

  localparam int NUM_ENG   = 4;
  localparam int JOB_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               ap_start;
  logic               ap_continue;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_idle;
  logic [NUM_ENG-1:0] op_start;
  logic [NUM_ENG-1:0] end_conv;
  logic [NUM_ENG-1:0] wmst_done;
`ifdef ACC_ENG_PERF_EN
  logic [31:0]        perf_busy_cyc;
  logic [31:0]        perf_jobs;
`endif

  int checks = 0;
  int errors = 0;

  acc_eng_ctrl_mc #(
    .NUM_ENG   (NUM_ENG),
    .JOB_DEPTH (JOB_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ap_start    (ap_start),
    .ap_continue (ap_continue),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .op_start    (op_start),
    .end_conv    (end_conv),
    .wmst_done   (wmst_done)
`ifdef ACC_ENG_PERF_EN
    ,
    .perf_busy_cyc (perf_busy_cyc),
    .perf_jobs     (perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       cont;
    logic [3:0] ec;
    logic [3:0] wd;
    logic [3:0] op;
    int         pend;
    int         done;
    logic       rdy;
  } vec_t;

  vec_t tbl [24];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    end_conv    = '0;
    wmst_done   = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_op"},    32'(op_start), 32'h0);
    chk_val({tag, "_done"},  32'(ap_done), 32'h0);
    chk_val({tag, "_ready"}, 32'(ap_ready), 32'h1);
    chk_val({tag, "_idle"},  32'(ap_idle), 32'h1);
    chk_val({tag, "_pend"},  32'(dut.pend_cnt), 32'h0);
    chk_val({tag, "_dcnt"},  32'(dut.done_cnt), 32'h0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    clr_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals(tag);
    step();
    rst = 1'b0;
  endtask

  initial begin
    // st cont ec wd | op pend done rdy
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1, 0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 1, 0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h2, 1, 0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h4, 1, 0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h8, 1, 0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2, 0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3, 0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4, 1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 3, 1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4, 1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 4, 1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'hA, 4'h0, 4, 3, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h2, 3, 3, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h8, 2, 2, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 2, 1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 2, 1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 1, 1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 1, 1, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 1, 1, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 1, 1, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 1, 2, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 0, 2, 1'b1};

    rst = 1'b1;
    clr_inputs();
    repeat (2) step();
    chk_reset_vals("por");
    rst = 1'b0;

    // Single job through engine 0.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    chk_val("t1_acc_op",   32'(op_start), 32'h0);
    chk_val("t1_acc_pend", 32'(dut.pend_cnt), 32'h1);
    chk_val("t1_acc_idle", 32'(ap_idle), 32'h0);
    step();
    chk_val("t1_disp_op",   32'(op_start), 32'h1);
    chk_val("t1_disp_pend", 32'(dut.pend_cnt), 32'h0);
    chk_val("t1_disp_idle", 32'(ap_idle), 32'h0);
    step();
    chk_val("t1_op_pulse", 32'(op_start), 32'h0);
    repeat (3) step();
    end_conv = 4'h1;
    step();
    end_conv = 4'h0;
    chk_val("t1_ec_done", 32'(ap_done), 32'h0);
    chk_val("t1_ec_idle", 32'(ap_idle), 32'h0);
    repeat (3) step();
    wmst_done = 4'h1;
    step();
    wmst_done = 4'h0;
    chk_val("t1_wd_done", 32'(ap_done), 32'h1);
    chk_val("t1_wd_dcnt", 32'(dut.done_cnt), 32'h1);
    chk_val("t1_wd_idle", 32'(ap_idle), 32'h1);
    step();
    chk_val("t1_hold_done", 32'(ap_done), 32'h1);
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    chk_val("t1_ack_done", 32'(ap_done), 32'h0);
    chk_val("t1_ack_dcnt", 32'(dut.done_cnt), 32'h0);
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    chk_val("t1_spur_ack_done", 32'(ap_done), 32'h0);
    chk_val("t1_spur_ack_dcnt", 32'(dut.done_cnt), 32'h0);

    // Round robin, backpressure, simultaneous completions, ordering cases.
    do_reset("rst_a");
    for (int n = 0; n < 24; n++) begin
      ap_start    = tbl[n].st;
      ap_continue = tbl[n].cont;
      end_conv    = tbl[n].ec;
      wmst_done   = tbl[n].wd;
      step();
      clr_inputs();
      chk_val($sformatf("v%0d_op", n),    32'(op_start), 32'(tbl[n].op));
      chk_val($sformatf("v%0d_pend", n),  32'(dut.pend_cnt), 32'(tbl[n].pend));
      chk_val($sformatf("v%0d_dcnt", n),  32'(dut.done_cnt), 32'(tbl[n].done));
      chk_val($sformatf("v%0d_done", n),  32'(ap_done), 32'(tbl[n].done != 0));
      chk_val($sformatf("v%0d_ready", n), 32'(ap_ready), 32'(tbl[n].rdy));
      chk_val($sformatf("v%0d_idle", n),  32'(ap_idle), 32'h0);
    end

    // Reset while engines run, done_cnt=2 and an op_start pulse is high.
    do_reset("rst_mid");
    for (int n = 0; n < 4; n++) begin
      step();
      chk_val($sformatf("post_rst%0d_op", n),   32'(op_start), 32'h0);
      chk_val($sformatf("post_rst%0d_idle", n), 32'(ap_idle), 32'h1);
      chk_val($sformatf("post_rst%0d_rdy", n),  32'(ap_ready), 32'h1);
      chk_val($sformatf("post_rst%0d_done", n), 32'(ap_done), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
